// File: rtl/pixel_stream_source_if.sv
// Pixel-stream bundle between the synthetic source and the localization chain.
// The master side is the source: it takes the enable and frame configuration
// and drives the pixel data, coordinates and framing strobes.
interface pixel_stream_source_if #(
    parameter int PIXEL_DEPTH = 8
);
    logic                   en;
    logic [1:0]             pattern_sel;
    logic [PIXEL_DEPTH-1:0] fg_R;
    logic [PIXEL_DEPTH-1:0] fg_G;
    logic [PIXEL_DEPTH-1:0] fg_B;
    logic [12:0]            paddle_x;
    logic [12:0]            paddle_y;

    logic [PIXEL_DEPTH-1:0] output_R;
    logic [PIXEL_DEPTH-1:0] output_G;
    logic [PIXEL_DEPTH-1:0] output_B;
    logic                   output_valid;
    logic [12:0]            row;
    logic [12:0]            col;
    logic                   sof;
    logic                   eol;

    modport master (
        input  en, pattern_sel, fg_R, fg_G, fg_B, paddle_x, paddle_y,
        output output_R, output_G, output_B, output_valid, row, col, sof, eol
    );

    modport slave (
        output en, pattern_sel, fg_R, fg_G, fg_B, paddle_x, paddle_y,
        input  output_R, output_G, output_B, output_valid, row, col, sof, eol
    );
endinterface

// File: rtl/pixel_stream_source.sv
// Synthetic raster source: free-running h/v counters with blanking, four test
// patterns (black, colour bars, paddle rectangle, gray ramp) and sof/eol strobes.
// Frame configuration is shadowed at the (0,0) pixel so mid-frame changes only
// take effect on the next frame.
// Optional build macro: MOVING_PADDLE_EN -- paddle top row bounces vertically by
// 4 lines per frame instead of coming from paddle_y.
//
// state     | meaning
// ----------+--------------------------------------------
// ST_ACTIVE | h < LINE_WIDTH and v < FRAME_HEIGHT, pixels valid
// ST_HBLANK | h >= LINE_WIDTH on an active line
// ST_VBLANK | v >= FRAME_HEIGHT, whole line blank
module pixel_stream_source #(
    parameter int PIXEL_DEPTH  = 8,
    parameter int LINE_WIDTH   = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int H_BLANK      = 160,
    parameter int V_BLANK      = 45,
    parameter int PADDLE_W     = 32,
    parameter int PADDLE_H     = 96
) (
    input logic                   clk,
    input logic                   rst,
    pixel_stream_source_if.master pix
);
    localparam logic [12:0] H_LAST     = 13'(LINE_WIDTH + H_BLANK - 1);
    localparam logic [12:0] V_LAST     = 13'(FRAME_HEIGHT + V_BLANK - 1);
    localparam logic [12:0] H_ACT_END  = 13'(LINE_WIDTH);
    localparam logic [12:0] H_ACT_LAST = 13'(LINE_WIDTH - 1);
    localparam logic [12:0] V_ACT_END  = 13'(FRAME_HEIGHT);

    typedef enum logic [1:0] {ST_ACTIVE, ST_HBLANK, ST_VBLANK} state_t;

    state_t                 state, state_nxt;
    logic [12:0]            h, v, h_nxt, v_nxt;
    logic                   h_wrap, v_wrap, frame_start;

    logic [1:0]             sh_pat, cur_pat;
    logic [PIXEL_DEPTH-1:0] sh_r, sh_g, sh_b, cur_r, cur_g, cur_b;
    logic [12:0]            sh_x, sh_y, cur_x, cur_y, y_src;

    logic [15:0]            h_x8;
    logic [2:0]             bar_idx;
    logic [13:0]            x_lo, x_hi, y_lo, y_hi;
    logic                   in_paddle;

    logic [PIXEL_DEPTH-1:0] r_nxt, g_nxt, b_nxt;
    logic                   valid_nxt, sof_nxt, eol_nxt;

    logic [PIXEL_DEPTH-1:0] r_q, g_q, b_q;
    logic                   valid_q, sof_q, eol_q;
    logic [12:0]            row_q, col_q;

    assign h_wrap      = (h == H_LAST);
    assign v_wrap      = h_wrap && (v == V_LAST);
    assign h_nxt       = h_wrap ? 13'd0 : h + 13'd1;
    assign v_nxt       = h_wrap ? (v_wrap ? 13'd0 : v + 13'd1) : v;
    assign frame_start = (h == 13'd0) && (v == 13'd0);

    // State and raster counters; everything stalls while en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ACTIVE;
            h     <= 13'd0;
            v     <= 13'd0;
        end else if (pix.en) begin
            state <= state_nxt;
            h     <= h_nxt;
            v     <= v_nxt;
        end
    end

    // Next state follows the counter transitions of this cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACTIVE: if (h_nxt == H_ACT_END) state_nxt = ST_HBLANK;
            ST_HBLANK: if (h_wrap) state_nxt = (v_nxt == V_ACT_END) ? ST_VBLANK : ST_ACTIVE;
            ST_VBLANK: if (v_wrap) state_nxt = ST_ACTIVE;
            default:   state_nxt = ST_ACTIVE;
        endcase
    end

`ifdef MOVING_PADDLE_EN
    localparam logic [12:0] Y_MAX = 13'(FRAME_HEIGHT - PADDLE_H);

    logic [12:0] y_pos;
    logic        y_down;

    // Bouncing paddle: step 4 lines per frame, clamping on and reversing at the bounds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_pos  <= 13'd0;
            y_down <= 1'b0;
        end else if (pix.en && frame_start) begin
            if (!y_down) begin
                if (y_pos + 13'd4 >= Y_MAX) begin
                    y_pos  <= Y_MAX;
                    y_down <= 1'b1;
                end else begin
                    y_pos <= y_pos + 13'd4;
                end
            end else begin
                if (y_pos <= 13'd4) begin
                    y_pos  <= 13'd0;
                    y_down <= 1'b0;
                end else begin
                    y_pos <= y_pos - 13'd4;
                end
            end
        end
    end

    assign y_src = y_pos;
`else
    assign y_src = pix.paddle_y;
`endif

    // Frame shadow registers, loaded on the (0,0) pixel edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_pat <= 2'd0;
            sh_r   <= '0;
            sh_g   <= '0;
            sh_b   <= '0;
            sh_x   <= 13'd0;
            sh_y   <= 13'd0;
        end else if (pix.en && frame_start) begin
            sh_pat <= pix.pattern_sel;
            sh_r   <= pix.fg_R;
            sh_g   <= pix.fg_G;
            sh_b   <= pix.fg_B;
            sh_x   <= pix.paddle_x;
            sh_y   <= y_src;
        end
    end

    // The (0,0) pixel is rendered from the values being latched on that same edge.
    assign cur_pat = frame_start ? pix.pattern_sel : sh_pat;
    assign cur_r   = frame_start ? pix.fg_R : sh_r;
    assign cur_g   = frame_start ? pix.fg_G : sh_g;
    assign cur_b   = frame_start ? pix.fg_B : sh_b;
    assign cur_x   = frame_start ? pix.paddle_x : sh_x;
    assign cur_y   = frame_start ? y_src : sh_y;

    assign h_x8    = {h, 3'b000};
    assign bar_idx = 3'(h_x8 / 16'(LINE_WIDTH));

    // 14-bit bounds so a rectangle running off the right/bottom edge clips instead of wrapping.
    assign x_lo      = {1'b0, cur_x};
    assign x_hi      = x_lo + 14'(PADDLE_W);
    assign y_lo      = {1'b0, cur_y};
    assign y_hi      = y_lo + 14'(PADDLE_H);
    assign in_paddle = ({1'b0, h} >= x_lo) && ({1'b0, h} < x_hi) &&
                       ({1'b0, v} >= y_lo) && ({1'b0, v} < y_hi);

    // Pixel value and strobes for the current counter position.
    always_comb begin
        r_nxt     = '0;
        g_nxt     = '0;
        b_nxt     = '0;
        valid_nxt = 1'b0;
        sof_nxt   = 1'b0;
        eol_nxt   = 1'b0;
        if (state == ST_ACTIVE) begin
            valid_nxt = 1'b1;
            sof_nxt   = frame_start;
            eol_nxt   = (h == H_ACT_LAST);
            case (cur_pat)
                2'd1: begin
                    // bar order white,yellow,cyan,green,magenta,red,blue,black
                    r_nxt = {PIXEL_DEPTH{~bar_idx[1]}};
                    g_nxt = {PIXEL_DEPTH{~bar_idx[2]}};
                    b_nxt = {PIXEL_DEPTH{~bar_idx[0]}};
                end
                2'd2: begin
                    if (in_paddle) begin
                        r_nxt = cur_r;
                        g_nxt = cur_g;
                        b_nxt = cur_b;
                    end
                end
                2'd3: begin
                    r_nxt = h[PIXEL_DEPTH+1:2];
                    g_nxt = h[PIXEL_DEPTH+1:2];
                    b_nxt = h[PIXEL_DEPTH+1:2];
                end
                default: ;
            endcase
        end
    end

    // Output register: one cycle after the counters; blanked and frozen while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            row_q   <= 13'd0;
            col_q   <= 13'd0;
        end else if (pix.en) begin
            r_q     <= r_nxt;
            g_q     <= g_nxt;
            b_q     <= b_nxt;
            valid_q <= valid_nxt;
            sof_q   <= sof_nxt;
            eol_q   <= eol_nxt;
            row_q   <= v;
            col_q   <= h;
        end else begin
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
        end
    end

    assign pix.output_R     = r_q;
    assign pix.output_G     = g_q;
    assign pix.output_B     = b_q;
    assign pix.output_valid = valid_q;
    assign pix.sof          = sof_q;
    assign pix.eol          = eol_q;
    assign pix.row          = row_q;
    assign pix.col          = col_q;
endmodule

// File: tb/tb_pixel_stream_source.sv
// Directed bench for pixel_stream_source on a reduced raster (64x48 active,
// 16 h-blank, 4 v-blank, 8x12 paddle) so whole frames fit in a short run.
module tb_pixel_stream_source;
    localparam int PD    = 8;
    localparam int LW    = 64;
    localparam int FH    = 48;
    localparam int HB    = 16;
    localparam int VB    = 4;
    localparam int PW    = 8;
    localparam int PH    = 12;
    localparam int FRAME = (LW + HB) * (FH + VB);

    logic clk;
    logic rst;
    int   nvec;
    int   nerr;

    pixel_stream_source_if #(.PIXEL_DEPTH(PD)) pif ();

    pixel_stream_source #(
        .PIXEL_DEPTH(PD), .LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .H_BLANK(HB),
        .V_BLANK(VB), .PADDLE_W(PW), .PADDLE_H(PH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pix(pif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pif.en = 1'b0;
        pif.pattern_sel = 2'd1;
        pif.fg_R = 8'h00; pif.fg_G = 8'h00; pif.fg_B = 8'h00;
        pif.paddle_x = 13'd0; pif.paddle_y = 13'd0;
        repeat (3) tick();
        nvec++; if (pif.output_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid: got %b expected 0", pif.output_valid); end
        nvec++; if (pif.sof !== 1'b0 || pif.eol !== 1'b0) begin nerr++; $display("FAIL rst_strobes: got sof=%b eol=%b expected 0/0", pif.sof, pif.eol); end
        nvec++; if (pif.row !== 13'd0 || pif.col !== 13'd0) begin nerr++; $display("FAIL rst_coords: got %0d,%0d expected 0,0", pif.row, pif.col); end
        nvec++; if ({pif.output_R, pif.output_G, pif.output_B} !== 24'h0) begin nerr++; $display("FAIL rst_rgb: got %h expected 000000", {pif.output_R, pif.output_G, pif.output_B}); end
        rst = 1'b0;
        pif.en = 1'b1;
        tick();
        nvec++; if (pif.output_valid !== 1'b1 || pif.sof !== 1'b1) begin nerr++; $display("FAIL first_pixel_strobe: got valid=%b sof=%b expected 1/1", pif.output_valid, pif.sof); end
        nvec++; if (pif.row !== 13'd0 || pif.col !== 13'd0) begin nerr++; $display("FAIL first_pixel_coord: got %0d,%0d expected 0,0", pif.row, pif.col); end
        nvec++; if ({pif.output_R, pif.output_G, pif.output_B} !== 24'hffffff) begin nerr++; $display("FAIL first_pixel_rgb: got %h expected ffffff", {pif.output_R, pif.output_G, pif.output_B}); end
    endtask

    task automatic test_bars();
        int nval0 = 0, ninv0 = 0, neol = 0, neol_bad = 0, nstray = 0;
        logic [23:0] rgb;
        for (int i = 0; i < 2 * (LW + HB); i++) begin
            rgb = {pif.output_R, pif.output_G, pif.output_B};
            if (i < LW + HB) begin
                if (pif.output_valid) nval0++; else ninv0++;
            end
            if (!pif.output_valid && rgb != 24'h0) nstray++;
            if (pif.eol) begin
                neol++;
                if (pif.col != 13'(LW - 1) || !pif.output_valid) neol_bad++;
            end
            if (pif.output_valid && pif.row == 13'd0) begin
                case (pif.col)
                    13'd8:  begin nvec++; if (rgb !== 24'hffff00) begin nerr++; $display("FAIL bar_yellow: got %h expected ffff00", rgb); end end
                    13'd16: begin nvec++; if (rgb !== 24'h00ffff) begin nerr++; $display("FAIL bar_cyan: got %h expected 00ffff", rgb); end end
                    13'd24: begin nvec++; if (rgb !== 24'h00ff00) begin nerr++; $display("FAIL bar_green: got %h expected 00ff00", rgb); end end
                    13'd40: begin nvec++; if (rgb !== 24'hff0000) begin nerr++; $display("FAIL bar_red: got %h expected ff0000", rgb); end end
                    13'd48: begin nvec++; if (rgb !== 24'h0000ff) begin nerr++; $display("FAIL bar_blue: got %h expected 0000ff", rgb); end end
                    13'd63: begin nvec++; if (rgb !== 24'h000000) begin nerr++; $display("FAIL bar_black: got %h expected 000000", rgb); end end
                    default: ;
                endcase
            end
            tick();
        end
        nvec++; if (nval0 !== LW) begin nerr++; $display("FAIL line_valid_count: got %0d expected %0d", nval0, LW); end
        nvec++; if (ninv0 !== HB) begin nerr++; $display("FAIL line_blank_count: got %0d expected %0d", ninv0, HB); end
        nvec++; if (neol !== 2 || neol_bad !== 0) begin nerr++; $display("FAIL bar_eol: got count=%0d misplaced=%0d expected 2/0", neol, neol_bad); end
        nvec++; if (nstray !== 0) begin nerr++; $display("FAIL bar_blank_rgb: got %0d nonzero blank pixels expected 0", nstray); end
    endtask

    task automatic test_paddle();
        int nred = 0, nbad = 0, nother = 0, nvalid = 0, nstray = 0, nsof = 0, neol = 0;
        bit got = 0;
        logic [23:0] rgb;
        pif.pattern_sel = 2'd2;
        pif.paddle_x = 13'd10; pif.paddle_y = 13'd20;
        pif.fg_R = 8'hff; pif.fg_G = 8'h00; pif.fg_B = 8'h00;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (pif.sof) begin got = 1; break; end
        end
        nvec++; if (got !== 1'b1) begin nerr++; $display("FAIL paddle_sof_wait: got no sof expected one within %0d cycles", 2 * FRAME); end
        for (int i = 0; i < FRAME; i++) begin
            rgb = {pif.output_R, pif.output_G, pif.output_B};
            if (pif.output_valid) begin
                nvalid++;
                if (rgb == 24'hff0000) begin
                    nred++;
                    if (pif.col < 13'd10 || pif.col > 13'd17 || pif.row < 13'd20 || pif.row > 13'd31) nbad++;
                end else if (rgb != 24'h0) nother++;
            end else if (rgb != 24'h0) nstray++;
            if (pif.sof) nsof++;
            if (pif.eol) neol++;
            if (pif.output_valid && pif.row == 13'd24 && pif.col == 13'd0) pif.pattern_sel = 2'd3;
            tick();
        end
        nvec++; if (nred !== PW * PH) begin nerr++; $display("FAIL paddle_red_count: got %0d expected %0d", nred, PW * PH); end
        nvec++; if (nbad !== 0) begin nerr++; $display("FAIL paddle_outside: got %0d red pixels outside rect expected 0", nbad); end
        nvec++; if (nother !== 0) begin nerr++; $display("FAIL paddle_background: got %0d non-black background pixels expected 0", nother); end
        nvec++; if (nvalid !== LW * FH) begin nerr++; $display("FAIL frame_valid_count: got %0d expected %0d", nvalid, LW * FH); end
        nvec++; if (nstray !== 0) begin nerr++; $display("FAIL paddle_blank_rgb: got %0d expected 0", nstray); end
        nvec++; if (nsof !== 1 || neol !== FH) begin nerr++; $display("FAIL frame_strobes: got sof=%0d eol=%0d expected 1/%0d", nsof, neol, FH); end
    endtask

    task automatic test_gray();
        logic [23:0] rgb;
        nvec++; if (pif.sof !== 1'b1) begin nerr++; $display("FAIL gray_frame_start: got sof=%b expected 1", pif.sof); end
        for (int i = 0; i < LW; i++) begin
            rgb = {pif.output_R, pif.output_G, pif.output_B};
            case (pif.col)
                13'd0:  begin nvec++; if (rgb !== 24'h000000) begin nerr++; $display("FAIL gray_col0: got %h expected 000000", rgb); end end
                13'd4:  begin nvec++; if (rgb !== 24'h010101) begin nerr++; $display("FAIL gray_col4: got %h expected 010101", rgb); end end
                13'd40: begin nvec++; if (rgb !== 24'h0a0a0a) begin nerr++; $display("FAIL gray_col40: got %h expected 0a0a0a", rgb); end end
                13'd63: begin nvec++; if (rgb !== 24'h0f0f0f) begin nerr++; $display("FAIL gray_col63: got %h expected 0f0f0f", rgb); end end
                default: ;
            endcase
            tick();
        end
        pif.pattern_sel = 2'd2;
        pif.paddle_x = 13'd60;
        pif.paddle_y = 13'd44;
    endtask

    task automatic test_clip();
        int nred = 0, nbad = 0;
        bit got = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (pif.sof) begin got = 1; break; end
        end
        nvec++; if (got !== 1'b1) begin nerr++; $display("FAIL clip_sof_wait: got no sof expected one within %0d cycles", 2 * FRAME); end
        for (int i = 0; i < FRAME; i++) begin
            if (pif.output_valid && {pif.output_R, pif.output_G, pif.output_B} == 24'hff0000) begin
                nred++;
                if (pif.col < 13'd60 || pif.row < 13'd44) nbad++;
            end
            tick();
        end
        nvec++; if (nred !== 16) begin nerr++; $display("FAIL clip_red_count: got %0d expected 16", nred); end
        nvec++; if (nbad !== 0) begin nerr++; $display("FAIL clip_wrap: got %0d wrapped red pixels expected 0", nbad); end
    endtask

    task automatic test_en_pause();
        int  cnt = 0, nfrozen_bad = 0;
        bit  got = 0;
        nvec++; if (pif.sof !== 1'b1) begin nerr++; $display("FAIL pause_frame_start: got sof=%b expected 1", pif.sof); end
        for (int i = 0; i < 3 * (LW + HB) + 20; i++) begin tick(); cnt++; end
        nvec++; if (pif.row !== 13'd3 || pif.col !== 13'd20 || pif.output_valid !== 1'b1) begin nerr++; $display("FAIL pause_position: got %0d,%0d v=%b expected 3,20 v=1", pif.row, pif.col, pif.output_valid); end
        pif.en = 1'b0;
        for (int i = 0; i < 37; i++) begin
            tick(); cnt++;
            if (pif.row != 13'd3 || pif.col != 13'd20 || pif.output_valid || pif.sof || pif.eol) nfrozen_bad++;
        end
        nvec++; if (nfrozen_bad !== 0) begin nerr++; $display("FAIL pause_frozen: got %0d bad cycles expected 0", nfrozen_bad); end
        pif.en = 1'b1;
        tick(); cnt++;
        nvec++; if (pif.row !== 13'd3 || pif.col !== 13'd21 || pif.output_valid !== 1'b1) begin nerr++; $display("FAIL pause_resume: got %0d,%0d v=%b expected 3,21 v=1", pif.row, pif.col, pif.output_valid); end
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(); cnt++;
            if (pif.sof) begin got = 1; break; end
        end
        nvec++; if (got !== 1'b1 || cnt !== FRAME + 37) begin nerr++; $display("FAIL pause_period: got %0d cycles expected %0d", cnt, FRAME + 37); end
    endtask

    task automatic test_reset_midframe();
        int cnt = 0;
        bit got = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (pif.row == 13'd30 && pif.col == 13'd5) begin got = 1; break; end
        end
        nvec++; if (got !== 1'b1 || pif.output_valid !== 1'b1) begin nerr++; $display("FAIL midreset_reach: got reached=%b v=%b expected 1/1", got, pif.output_valid); end
        rst = 1'b1;
        #1;
        nvec++; if (pif.output_valid !== 1'b0 || pif.row !== 13'd0 || pif.col !== 13'd0) begin nerr++; $display("FAIL midreset_async: got v=%b %0d,%0d expected 0 0,0", pif.output_valid, pif.row, pif.col); end
        repeat (2) tick();
        rst = 1'b0;
        tick();
        nvec++; if (pif.sof !== 1'b1 || pif.row !== 13'd0 || pif.col !== 13'd0) begin nerr++; $display("FAIL midreset_restart: got sof=%b %0d,%0d expected 1 0,0", pif.sof, pif.row, pif.col); end
        got = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(); cnt++;
            if (pif.sof) begin got = 1; break; end
        end
        nvec++; if (got !== 1'b1 || cnt !== FRAME) begin nerr++; $display("FAIL frame_period: got %0d cycles expected %0d", cnt, FRAME); end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst = 1'b1;
        test_reset();
        test_bars();
        test_paddle();
        test_gray();
        test_clip();
        test_en_pause();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule
